// File: rtl/data_read_scheduler.sv
// data_read_scheduler: arbitrates the shared data-FIFO read port between the
// STP, EVP and EVB command modules. It owns the registered read address and
// the FIFO fill count, and moves the address only on legal pops.
//
// Command handshake: a command transfers on any clock edge where cmd_valid
// and cmd_ready are both high. cmd_ready is high only in IDLE. Upstream holds
// cmd_valid and instr stable until the transfer happens.

package data_read_scheduler_pkg;
  // Number of address bits for a depth of 'value'; a depth of 1 still gets 1 bit.
  function automatic int log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction
endpackage

module data_read_scheduler
  import data_read_scheduler_pkg::*;
#(
  parameter int buffer_size = 1024,
  localparam int AW = log2(buffer_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    instr,
  output logic          cmd_ready,
  input  logic          wr_en_data,
  input  logic          pop_STP,
  input  logic          pop_EVP,
  input  logic          pop_EVB,
  input  logic          done_STP,
  input  logic          done_EVP,
  input  logic          done_EVB,
  output logic          en_STP,
  output logic          en_EVP,
  output logic          en_EVB,
  output logic [AW-1:0] rd_addr_data,
  output logic [AW:0]   data_count,
  output logic          data_empty,
  output logic          data_full,
  output logic          err_flag,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(buffer_size);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [2:0]    en_q, en_d;          // bit 0 STP, bit 1 EVP, bit 2 EVB
  logic [AW-1:0] rd_addr_q;
  logic [AW:0]   count_q;
  logic          err_q;

  logic [2:0]    pop_vec;
  logic [2:0]    done_vec;
  logic [2:0]    legal_mask;
  logic          legal_pop;
  logic          illegal_pop;
  logic          overflow;

  assign pop_vec  = {pop_EVB, pop_EVP, pop_STP};
  assign done_vec = {done_EVB, done_EVP, done_STP};

  assign data_empty = (count_q == '0);
  assign data_full  = (count_q == FULL_CNT);

  // A pop counts only when it comes from the granted module and there is data.
  assign legal_pop   = (state_q == S_RUN) && |(pop_vec & en_q) && !data_empty;
  assign legal_mask  = legal_pop ? en_q : 3'b000;
  assign illegal_pop = |(pop_vec & ~legal_mask);
  // The FLUSH cycle clears the count first, so a write there can never overflow.
  assign overflow    = (state_q != S_FLUSH) && wr_en_data && !legal_pop && data_full;

  // State and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      en_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
    end
  end

  // Next state and next grant: accept in IDLE, release on the granted done.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    case (state_q)
      S_IDLE: begin
        en_d = 3'b000;
        if (cmd_valid) begin
          if (instr == 2'b11) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_RUN;
            en_d    = 3'b001 << instr;
          end
        end
      end
      S_RUN: begin
        if (|(done_vec & en_q)) begin
          state_d = S_IDLE;
          en_d    = 3'b000;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        en_d    = 3'b000;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 3'b000;
      end
    endcase
  end

  // Read address, fill count and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (illegal_pop || overflow) err_q <= 1'b1;
      if (state_q == S_FLUSH) begin
        // Skip over everything still held; a full FIFO wraps back onto itself.
        rd_addr_q <= rd_addr_q + count_q[AW-1:0];
        count_q   <= wr_en_data ? ONE_CNT : '0;
      end else begin
        if (legal_pop) rd_addr_q <= rd_addr_q + 1'b1;
        if (wr_en_data && !legal_pop && !data_full) begin
          count_q <= count_q + ONE_CNT;
        end else if (!wr_en_data && legal_pop) begin
          count_q <= count_q - ONE_CNT;
        end
      end
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign en_STP       = en_q[0];
  assign en_EVP       = en_q[1];
  assign en_EVB       = en_q[2];
  assign rd_addr_data = rd_addr_q;
  assign data_count   = count_q;
  assign err_flag     = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_data_read_scheduler.sv
// Testbench for data_read_scheduler: directed scenarios followed by random
// traffic, checked against a behavioural model through an expected queue.
module tb_data_read_scheduler;

  localparam int BS = 8;
  localparam int AW = 3;
  localparam int EW = 2*AW + 8;

  // Expected-vector field positions.
  localparam int P_ERR   = 0;
  localparam int P_FULL  = 1;
  localparam int P_EMPTY = 2;
  localparam int P_CNT   = 3;
  localparam int P_ADDR  = 4 + AW;
  localparam int P_EN    = 4 + 2*AW;
  localparam int P_RDY   = 7 + 2*AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic [1:0]    instr = 2'b00;
  logic          cmd_ready;
  logic          wr_en_data = 1'b0;
  logic          pop_STP = 1'b0, pop_EVP = 1'b0, pop_EVB = 1'b0;
  logic          done_STP = 1'b0, done_EVP = 1'b0, done_EVB = 1'b0;
  logic          en_STP, en_EVP, en_EVB;
  logic [AW-1:0] rd_addr_data;
  logic [AW:0]   data_count;
  logic          data_empty, data_full, err_flag;
  logic [1:0]    state_dbg;

  data_read_scheduler #(.buffer_size(BS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .instr(instr), .cmd_ready(cmd_ready),
    .wr_en_data(wr_en_data),
    .pop_STP(pop_STP), .pop_EVP(pop_EVP), .pop_EVB(pop_EVB),
    .done_STP(done_STP), .done_EVP(done_EVP), .done_EVB(done_EVB),
    .en_STP(en_STP), .en_EVP(en_EVP), .en_EVB(en_EVB),
    .rd_addr_data(rd_addr_data), .data_count(data_count),
    .data_empty(data_empty), .data_full(data_full), .err_flag(err_flag),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 serving a module, 2 flushing. grant: module index or -1.
  int m_mode  = 0;
  int m_grant = -1;
  int m_addr  = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_grant = -1; m_addr = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic model_update(input bit wr, input bit cv, input logic [1:0] ins,
                              input logic [2:0] pops, input logic [2:0] dones);
    bit legal;
    legal = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (pops[j]) begin
        if (m_mode == 1 && j == m_grant && m_cnt > 0) legal = 1'b1;
        else m_err = 1'b1;
      end
    end
    if (m_mode == 2) begin
      m_addr = (m_addr + m_cnt) % BS;
      m_cnt  = wr ? 1 : 0;
      m_mode = 0;
    end else begin
      if (legal) m_addr = (m_addr + 1) % BS;
      if (wr && !legal) begin
        if (m_cnt == BS) m_err = 1'b1;
        else m_cnt = m_cnt + 1;
      end else if (!wr && legal) begin
        m_cnt = m_cnt - 1;
      end
      if (m_mode == 0 && cv) begin
        if (ins == 2'd3) m_mode = 2;
        else begin m_mode = 1; m_grant = int'(ins); end
      end else if (m_mode == 1 && dones[m_grant]) begin
        m_mode = 0; m_grant = -1;
      end
    end
  endtask

  function automatic logic [EW-1:0] model_pack();
    logic [2:0] en;
    en = (m_grant < 0) ? 3'b000 : 3'(1 << m_grant);
    return {(m_mode == 0), en, AW'(m_addr), (AW+1)'(m_cnt),
            (m_cnt == 0), (m_cnt == BS), m_err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit wr, input bit cv, input logic [1:0] ins,
                       input logic [2:0] pops, input logic [2:0] dones);
    @(posedge clk); #2;
    wr_en_data = wr; cmd_valid = cv; instr = ins;
    {pop_EVB, pop_EVP, pop_STP} = pops;
    {done_EVB, done_EVP, done_STP} = dones;
    model_update(wr, cv, ins, pops, dones);
    exp_q.push_back(model_pack());
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'd0, 3'b000, 3'b000);
  endtask

  task automatic pop_n(input logic [2:0] who, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, who, 3'b000);
  endtask

  task automatic cmd(input logic [1:0] ins);
    drive(1'b0, 1'b1, ins, 3'b000, 3'b000);
  endtask

  // Asynchronous reset asserted between edges, with an immediate output check.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    wr_en_data = 0; cmd_valid = 0; instr = 0;
    {pop_EVB, pop_EVP, pop_STP} = 3'b000;
    {done_EVB, done_EVP, done_STP} = 3'b000;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_addr"},  32'(rd_addr_data), 32'd0);
    check({tag, "_count"}, 32'(data_count), 32'd0);
    check({tag, "_empty"}, 32'(data_empty), 32'd1);
    check({tag, "_full"},  32'(data_full), 32'd0);
    check({tag, "_en"},    32'({en_EVB, en_EVP, en_STP}), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_err"},   32'(err_flag), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  // Compare one expected vector against the outputs just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cmd_ready",  32'(cmd_ready),    32'(mon_e[P_RDY]));
      check("en",         32'({en_EVB, en_EVP, en_STP}), 32'(mon_e[P_EN+2:P_EN]));
      check("rd_addr",    32'(rd_addr_data), 32'(mon_e[P_ADDR+AW-1:P_ADDR]));
      check("data_count", 32'(data_count),   32'(mon_e[P_CNT+AW:P_CNT]));
      check("data_empty", 32'(data_empty),   32'(mon_e[P_EMPTY]));
      check("data_full",  32'(data_full),    32'(mon_e[P_FULL]));
      check("err_flag",   32'(err_flag),     32'(mon_e[P_ERR]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit         pend;
    logic [1:0] pins;
    logic [2:0] pops, dones;
    bit         wr, accepted;

    do_reset("reset_init");

    // Basic STP: 5 pushes, grant, 3 pops, release.
    push_n(5);
    cmd(2'd0);
    pop_n(3'b001, 3);
    drive(0, 0, 0, 3'b000, 3'b001);
    drive(0, 0, 0, 3'b000, 3'b000);

    // Bring the address to 7 with count 2, then wrap through EVB.
    push_n(4);
    cmd(2'd0);
    pop_n(3'b001, 4);
    drive(0, 0, 0, 3'b000, 3'b001);
    cmd(2'd2);
    drive(0, 1, 2'd3, 3'b000, 3'b000);   // not accepted while busy
    pop_n(3'b100, 1);
    drive(0, 0, 0, 3'b000, 3'b001);      // foreign done ignored
    drive(0, 0, 0, 3'b000, 3'b100);

    // Error cases under an EVP grant.
    cmd(2'd1);
    pop_n(3'b001, 1);                    // wrong module
    pop_n(3'b010, 1);                    // legal, empties the FIFO
    pop_n(3'b010, 1);                    // empty pop
    push_n(1);
    drive(1, 0, 0, 3'b010, 3'b000);      // push and pop together
    drive(0, 0, 0, 3'b010, 3'b010);      // pop and done together

    // Fill to full, overflow, then flush with a concurrent write.
    push_n(8);
    push_n(1);
    drive(1, 1, 2'd3, 3'b000, 3'b000);
    drive(0, 0, 0, 3'b000, 3'b000);

    // Flush arithmetic: address 2 + count 4, then 6 + 4 wraps to 2.
    do_reset("reset_flush");
    push_n(6);
    cmd(2'd0);
    pop_n(3'b001, 2);
    drive(0, 0, 0, 3'b000, 3'b001);
    cmd(2'd3);
    drive(0, 0, 0, 3'b000, 3'b000);
    push_n(4);
    cmd(2'd3);
    drive(0, 0, 0, 3'b000, 3'b000);

    // Reset in the middle of an EVB run, then a normal EVP command.
    push_n(3);
    cmd(2'd2);
    pop_n(3'b100, 2);
    do_reset("reset_midrun");
    push_n(1);
    cmd(2'd1);
    pop_n(3'b010, 1);
    drive(0, 0, 0, 3'b000, 3'b010);

    // Random traffic; upstream holds a command until it is accepted.
    do_reset("reset_rand");
    pend = 1'b0;
    pins = 2'd0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        pins = 2'($urandom_range(0, 3));
      end
      wr    = 1'($urandom_range(0, 1));
      pops  = 3'b000;
      dones = 3'b000;
      if (m_mode == 1 && $urandom_range(0, 1) == 1) pops[m_grant] = 1'b1;
      if ($urandom_range(0, 20) == 0) pops[$urandom_range(0, 2)] = 1'b1;
      if (m_mode == 1 && $urandom_range(0, 7) == 0) dones[m_grant] = 1'b1;
      if ($urandom_range(0, 15) == 0) dones[$urandom_range(0, 2)] = 1'b1;
      accepted = pend && (m_mode == 0);
      drive(wr, pend, pins, pops, dones);
      if (accepted) pend = 1'b0;
    end

    @(posedge clk); #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
